// File: rtl/branch_unit.sv
// branch_unit: execute-stage branch resolution and BHT direction prediction.
// Resolves RV32I conditional branches from the ALU compare code, redirects
// fetch on jumps and mispredictions, and trains a table of 2-bit saturating
// counters that supplies the fetch stage with a taken/not-taken guess.
// Optional feature macro: BRANCH_UNIT_STATS_EN (branch/mispredict counters).
module branch_unit #(
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jump,
    input  logic [2:0]  ex_funct3,
    input  logic [2:0]  ex_cmp_flag,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;

    logic             resolve;
    logic             is_jump;
    logic             is_branch;
    logic             taken;
    logic             mispredict;
    logic [2:0]       expected_code;
    logic             code_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic [31:0]      pc_plus4;

    // PC bits outside the table index are intentionally unused.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[31:IDX_W+2], pc_f[1:0]};

    assign lookup_idx   = pc_f[IDX_W+1:2];
    assign update_idx   = ex_pc[IDX_W+1:2];
    assign pred_taken_f = bht_q[lookup_idx][1];
    assign ctr_cur      = bht_q[update_idx];
    assign pc_plus4     = ex_pc + 32'd4;

    // Wrong-path work in the cycle after a redirect is dropped.
    assign resolve   = ex_valid & ~stall & ~redirect_q;
    assign is_jump   = resolve & ex_jump;
    assign is_branch = resolve & ex_branch & ~ex_jump;

    // Map branch funct3 onto the ALU compare code it expects.
    always_comb begin
        expected_code = 3'b000;
        code_valid    = 1'b1;
        case (ex_funct3)
            3'b000:  expected_code = 3'b000;
            3'b001:  expected_code = 3'b001;
            3'b100:  expected_code = 3'b010;
            3'b101:  expected_code = 3'b011;
            3'b110:  expected_code = 3'b100;
            3'b111:  expected_code = 3'b101;
            default: code_valid    = 1'b0;
        endcase
    end

    // Undefined funct3 never matches; flag codes 110/111 never equal a valid
    // expected code, so both fall out as not-taken.
    assign taken      = code_valid & (ex_cmp_flag == expected_code);
    assign mispredict = is_branch & (taken != ex_pred_taken);

    // Saturating counter next value for the entry being trained.
    always_comb begin
        ctr_d = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
    end

    // Redirect request and restart address for the next cycle.
    always_comb begin
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (is_jump) begin
            redirect_d    = 1'b1;
            redirect_pc_d = ex_target;
        end else if (mispredict) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken ? ex_target : pc_plus4;
        end
    end

    // Redirect pulse and held restart address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // BHT: reset to weakly not-taken, train on each resolved branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (is_branch) begin
            bht_q[update_idx] <= ctr_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Statistics next-state: count resolved branches and their mispredicts.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (is_branch)  branch_count_d     = branch_count_q + 32'd1;
        if (mispredict) mispredict_count_d = mispredict_count_q + 32'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed table-driven bench for branch_unit plus hand
// sequences for squash, stall and reset-override corner cases.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic [2:0]  ex_cmp_flag;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_checks;
    int n_fail;

    branch_unit #(.BHT_ENTRIES(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_jump          (ex_jump),
        .ex_funct3        (ex_funct3),
        .ex_cmp_flag      (ex_cmp_flag),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic [2:0]  flag;
        logic        pred;
        logic [31:0] tgt;
        logic        exp_red;
        logic [31:0] exp_rpc;
        logic        exp_pt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one edge and settle to a sample point away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic [2:0] f3, input logic [2:0] flag,
                         input logic pred, input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_branch     = br;
        ex_jump       = jmp;
        ex_funct3     = f3;
        ex_cmp_flag   = flag;
        ex_pred_taken = pred;
        ex_target     = tgt;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
        ex_jump   = 1'b0;
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        pc_f = pc;
        #1;
        chk(name, {31'd0, pred_taken_f}, {31'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pc_f     = 32'h100;
        stall    = 1'b0;
        ex_funct3 = 3'b000;
        ex_cmp_flag = 3'b000;
        ex_pc = '0;
        ex_target = '0;
        ex_pred_taken = 1'b0;
        idle();

        //           pc            br jmp f3      flag    pred tgt            red rpc           pt
        tbl[0]  = '{32'h00000100, 1, 0, 3'b000, 3'b000, 0, 32'h00000180, 1, 32'h00000180, 1};
        tbl[1]  = '{32'h00000104, 1, 0, 3'b100, 3'b011, 0, 32'h00000500, 0, 32'h00000180, 0};
        tbl[2]  = '{32'h00000104, 1, 0, 3'b100, 3'b011, 0, 32'h00000500, 0, 32'h00000180, 0};
        tbl[3]  = '{32'h00000108, 1, 0, 3'b001, 3'b001, 1, 32'h00000300, 0, 32'h00000180, 1};
        tbl[4]  = '{32'h0000010C, 1, 0, 3'b111, 3'b100, 1, 32'h00000700, 1, 32'h00000110, 0};
        tbl[5]  = '{32'h00000110, 1, 0, 3'b101, 3'b011, 0, 32'h00000050, 1, 32'h00000050, 1};
        tbl[6]  = '{32'h00000110, 1, 0, 3'b101, 3'b011, 1, 32'h00000050, 0, 32'h00000050, 1};
        tbl[7]  = '{32'h00000110, 1, 0, 3'b101, 3'b010, 1, 32'h00000050, 1, 32'h00000114, 1};
        tbl[8]  = '{32'h00000114, 1, 0, 3'b010, 3'b000, 1, 32'h00000900, 1, 32'h00000118, 0};
        tbl[9]  = '{32'h00000118, 1, 0, 3'b110, 3'b100, 0, 32'h00001000, 1, 32'h00001000, 1};
        tbl[10] = '{32'h0000011C, 1, 0, 3'b000, 3'b110, 0, 32'h00002000, 0, 32'h00001000, 0};
        tbl[11] = '{32'h00000200, 0, 1, 3'b000, 3'b000, 0, 32'h00000400, 1, 32'h00000400, 1};
        tbl[12] = '{32'hFFFFFFFC, 1, 0, 3'b111, 3'b100, 1, 32'h12345678, 1, 32'h00000000, 0};
        tbl[13] = '{32'h00000120, 1, 1, 3'b000, 3'b000, 0, 32'h00000800, 1, 32'h00000800, 0};

        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_branch_count", branch_count, 32'd0);
        chk("reset_mispredict_count", mispredict_count, 32'd0);
        check_pred("reset_pred_0x100", 32'h100, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pc, tbl[i].br, tbl[i].jmp, tbl[i].f3, tbl[i].flag,
                  tbl[i].pred, tbl[i].tgt);
            tick();
            idle();
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, tbl[i].exp_red});
            chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].exp_rpc);
            tick();
            chk($sformatf("vec%0d_redirect_drop", i), {31'd0, redirect}, 32'd0);
            check_pred($sformatf("vec%0d_pred", i), tbl[i].pc, tbl[i].exp_pt);
        end

        // Jump followed immediately by a would-be mispredicting branch.
        drive(32'h204, 0, 1, 3'b000, 3'b000, 0, 32'h440);
        tick();
        chk("squash_jump_redirect", {31'd0, redirect}, 32'd1);
        chk("squash_jump_rpc", redirect_pc, 32'h440);
        drive(32'h124, 1, 0, 3'b000, 3'b000, 0, 32'hA00);
        tick();
        idle();
        chk("squash_no_redirect", {31'd0, redirect}, 32'd0);
        chk("squash_rpc_held", redirect_pc, 32'h440);
        check_pred("squash_no_update", 32'h124, 1'b0);
        tick();
        chk("squash_still_quiet", {31'd0, redirect}, 32'd0);

        // Mispredicting branch held under stall for three cycles.
        drive(32'h128, 1, 0, 3'b000, 3'b000, 0, 32'h900);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_no_redirect", c), {31'd0, redirect}, 32'd0);
            chk($sformatf("stall%0d_rpc_held", c), redirect_pc, 32'h440);
        end
        check_pred("stall_no_update", 32'h128, 1'b0);
        stall = 1'b0;
        tick();
        idle();
        chk("stall_release_redirect", {31'd0, redirect}, 32'd1);
        chk("stall_release_rpc", redirect_pc, 32'h900);
        tick();
        chk("stall_single_pulse", {31'd0, redirect}, 32'd0);
        check_pred("stall_pred_after", 32'h128, 1'b1);
        // Counter must be 10 (one update), so one not-taken drops MSB.
        drive(32'h128, 1, 0, 3'b000, 3'b001, 1, 32'h900);
        tick();
        idle();
        chk("stall_followup_redirect", {31'd0, redirect}, 32'd1);
        chk("stall_followup_rpc", redirect_pc, 32'h12C);
        tick();
        check_pred("stall_single_update", 32'h128, 1'b0);

`ifdef BRANCH_UNIT_STATS_EN
        chk("stats_branch_count", branch_count, 32'd14);
        chk("stats_mispredict_count", mispredict_count, 32'd9);
`else
        chk("stats_branch_tied", branch_count, 32'd0);
        chk("stats_mispredict_tied", mispredict_count, 32'd0);
`endif

        // Reset asserted alongside a mispredicting branch.
        drive(32'h12C, 1, 0, 3'b000, 3'b000, 0, 32'hB00);
        rst_n = 1'b0;
        tick();
        idle();
        chk("rst_mid_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_mid_rpc", redirect_pc, 32'd0);
        chk("rst_mid_branch_count", branch_count, 32'd0);
        chk("rst_mid_mispredict_count", mispredict_count, 32'd0);
        check_pred("rst_mid_pred_0x100", 32'h100, 1'b0);
        check_pred("rst_mid_pred_0x110", 32'h110, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_quiet", {31'd0, redirect}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Execute-stage branch resolution and direction-prediction block for the RV32I core. It decodes the 3-bit compare code produced by the ALU against the branch funct3 to resolve BEQ/BNE/BLT/BGE/BLTU/BGEU and redirects fetch on jumps and mispredictions. It also maintains a table of 2-bit saturating counters that supplies the fetch stage with a taken/not-taken prediction. It sits between the ALU outputs and the PC-select logic.

## Interface
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, 4..1024
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- pc_f  in  32  fetch-stage PC, used for prediction lookup
- pred_taken_f  out  1  prediction for pc_f; combinational (counter MSB)
- ex_valid  in  1  execute stage holds a live instruction
- ex_branch  in  1  instruction is a conditional branch
- ex_jump  in  1  instruction is JAL/JALR
- ex_funct3  in  3  branch funct3
- ex_cmp_flag  in  3  ALU compare code: 000 eq, 001 ne, 010 lt, 011 ge, 100 ltu, 101 geu
- ex_pc  in  32  PC of the execute-stage instruction
- ex_target  in  32  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down from fetch
- stall  in  1  execute stage frozen this cycle
- redirect  out  1  registered one-cycle pulse: flush younger stages, load redirect_pc
- redirect_pc  out  32  registered fetch restart address
- branch_count  out  32  resolved conditional branches (BRANCH_UNIT_STATS_EN only)
- mispredict_count  out  32  mispredicted conditional branches (BRANCH_UNIT_STATS_EN only)

## Operation
- Resolve condition: resolve = ex_valid & ~stall & ~redirect. Inputs presented in a cycle where redirect=1 are wrong-path and are ignored entirely.
- Taken decode: funct3 maps to the expected code (000→000, 001→001, 100→010, 101→011, 110→100, 111→101). taken = (ex_cmp_flag == expected).
- Funct3 010/011, or flag codes 110/111, give taken=0. The branch is still counted and trained as not-taken.
- Conditional branch: mispredict = taken ≠ ex_pred_taken. On mispredict, redirect_pc = taken ? ex_target : ex_pc+4 (mod 2^32).
- Jump (ex_jump=1, with priority over ex_branch): always redirects to ex_target. No counter update, not counted.
- BHT index = pc[log2(BHT_ENTRIES)+1:2], using pc_f for lookup and ex_pc for update.
- BHT update on every resolved conditional branch: saturating increment if taken, decrement if not (00 ↔ 11).
- Fetch lookup of the entry being updated in the same cycle returns the pre-update value. There is no bypass.
- Reset: all counters → 01 (weakly not-taken), redirect=0, redirect_pc=0, counters=0.
- Reset asserted mid-operation overrides any pending update or redirect in that cycle.

## Timing
- Latency: resolution in cycle N → redirect/redirect_pc valid in cycle N+1, for exactly one cycle.
- redirect_pc holds its last value while redirect=0.
- The stall=1 cycle neither redirects nor updates state. The instruction is resolved in the first non-stall cycle it is presented.
- Back-to-back: a valid instruction in the cycle after a redirect is squashed, so at most one redirect occurs per two cycles.
- pred_taken_f is combinational from pc_f and counter state. It reflects updates from the previous edge.

## Configuration
- BRANCH_UNIT_STATS_EN defined:
  - branch_count increments on every resolved conditional branch.
  - mispredict_count increments on each conditional mispredict.
  - Both are 32-bit, wrap at 2^32, reset to 0, and hold during stall.
- Undefined: both ports are tied to 0 and no counter flops are generated. Prediction and redirect behaviour is identical.

## Test plan
- After reset, pc_f=0x100 → pred_taken_f=0. Branch at 0x100, funct3=000, flag=000, pred=0 → next cycle redirect=1, redirect_pc=ex_target=0x180. Counter goes 01→10, so pred_taken_f=1 for 0x100.
- BLT (funct3=100), flag=011, pred=0 → no redirect, counter saturates at 00 after two updates. branch_count=2, mispredict_count=0 (stats build).
- BGEU predicted taken, flag=100 → redirect_pc = ex_pc+4, e.g. 0xFFFFFFFC → 0x00000000 wrap. mispredict_count=1.
- JAL, ex_pc=0x200, target=0x400 → redirect=1, redirect_pc=0x400, BHT unchanged. A valid branch next cycle is ignored: no update, no redirect.
- Mispredicting branch held with stall=1 for 3 cycles → no redirect during the stall. A single redirect follows the cycle after stall drops, and the counter updates once.
- rst_n=0 asserted in the same cycle as a mispredict → redirect stays 0, counters read 01, stats read 0.
